// File: rtl/draw_hole_pkg.sv
// draw_hole_pkg: shared types, command encodings and default colours for the hole-grid renderer
package draw_hole_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, OCCUPIED = 2'd1, HIT = 2'd2} hole_state_t;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_OCCUPY = 2'd1, OP_CLEAR = 2'd2, OP_HIT = 2'd3} cmd_op_t;
  localparam logic [11:0] DEF_EMPTY_CLR = 12'h000;
  localparam logic [11:0] DEF_OCC_CLR   = 12'hA50;
  localparam logic [11:0] DEF_HIT_CLR   = 12'hF00;
  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
  } timing_t;
  function automatic logic [11:0] state_clr(hole_state_t s, logic [11:0] e, logic [11:0] o, logic [11:0] h);
    return s == HIT ? h : s == OCCUPIED ? o : e;
  endfunction
endpackage

// File: rtl/draw_hole_grid_cell.sv
// hole_cell: per-hole EMPTY/OCCUPIED/HIT state machine with frame countdown
module hole_cell
  import draw_hole_pkg::*;
#(
  parameter int HIT_FRAMES = 30
)(
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  input  logic [1:0]  i_cmd_op,
  input  logic        i_tick,
  output hole_state_t o_state,
  output logic [7:0]  o_count
);
  hole_state_t r_state;
  logic [7:0]  r_count;
  logic        w_occ, w_hit, w_clr, w_dec;
  assign w_occ   = i_cmd_valid && i_cmd_op == OP_OCCUPY && r_state == EMPTY;
  assign w_hit   = i_cmd_valid && i_cmd_op == OP_HIT && r_state == OCCUPIED;
  assign w_clr   = i_cmd_valid && i_cmd_op == OP_CLEAR && r_state != EMPTY;
  assign w_dec   = i_tick && r_state == HIT;
  assign o_state = r_state;
  assign o_count = r_count;
  // An accepted command pre-empts the frame tick; ignored commands let the tick through
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      r_state <= EMPTY;
      r_count <= 8'd0;
    end else if (w_occ) begin
      r_state <= OCCUPIED;
    end else if (w_hit) begin
      r_state <= HIT;
      r_count <= 8'(HIT_FRAMES);
    end else if (w_clr) begin
      r_state <= EMPTY;
      r_count <= 8'd0;
    end else if (w_dec) begin
      r_count <= r_count - 8'd1;
      r_state <= r_count == 8'd1 ? EMPTY : HIT;
    end
endmodule

// File: rtl/draw_hole_grid.sv
// draw_hole_grid: overlays a grid of stateful square holes onto the VGA pixel stream
module draw_hole_grid
  import draw_hole_pkg::*;
#(
  parameter int          ROWS       = 3,
  parameter int          COLS       = 3,
  parameter int          ORIGIN_X   = 185,
  parameter int          ORIGIN_Y   = 135,
  parameter int          PITCH_X    = 200,
  parameter int          PITCH_Y    = 150,
  parameter int          HOLE_SIZE  = 50,
  parameter logic [11:0] EMPTY_CLR  = DEF_EMPTY_CLR,
  parameter logic [11:0] OCC_CLR    = DEF_OCC_CLR,
  parameter logic [11:0] HIT_CLR    = DEF_HIT_CLR,
  parameter int          HIT_FRAMES = 30
)(
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic [10:0]          hcount_in,
  input  logic [10:0]          vcount_in,
  input  logic                 hsync_in,
  input  logic                 hblnk_in,
  input  logic                 vsync_in,
  input  logic                 vblnk_in,
  input  logic [11:0]          rgb_in,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [5:0]           cmd_idx,
  output logic [10:0]          hcount_out,
  output logic [10:0]          vcount_out,
  output logic                 hsync_out,
  output logic                 hblnk_out,
  output logic                 vsync_out,
  output logic                 vblnk_out,
  output logic [11:0]          rgb_out,
  output logic [ROWS*COLS-1:0] occ_mask,
  output logic                 hit_ack
);
  localparam int N = ROWS * COLS;
  timing_t     w_tin, r_t1, r_t2;
  logic [COLS-1:0] w_col, r_col;
  logic [ROWS-1:0] w_row, r_row;
  logic        r_blank;
  logic [11:0] r_rgb1, r_rgb2, w_pix;
  logic [N-1:0] w_sel, w_occ, w_in;
  hole_state_t w_state [N];
  logic [7:0]  w_count [N];
  logic        r_vblnk, w_tick, r_hit_ack;
  assign w_tin  = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};
  assign w_tick = vblnk_in & ~r_vblnk;
  // Edge sums are formed at 12 bits so the far edge of the last hole cannot wrap
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam logic [11:0] LO = 12'(ORIGIN_X + c * PITCH_X);
    localparam logic [11:0] HI = 12'(ORIGIN_X + c * PITCH_X + HOLE_SIZE);
    assign w_col[c] = {1'b0, hcount_in} >= LO && {1'b0, hcount_in} < HI;
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic [11:0] LO = 12'(ORIGIN_Y + r * PITCH_Y);
    localparam logic [11:0] HI = 12'(ORIGIN_Y + r * PITCH_Y + HOLE_SIZE);
    assign w_row[r] = {1'b0, vcount_in} >= LO && {1'b0, vcount_in} < HI;
  end
  for (genvar i = 0; i < N; i++) begin : g_cell
    assign w_sel[i] = cmd_valid && cmd_idx == 6'(i);
    assign w_occ[i] = w_state[i] == OCCUPIED;
    assign w_in[i]  = r_row[i / COLS] & r_col[i % COLS];
    hole_cell #(.HIT_FRAMES(HIT_FRAMES)) u_cell (
      .pclk        (pclk),
      .rst_n       (rst_n),
      .i_cmd_valid (w_sel[i]),
      .i_cmd_op    (cmd_op),
      .i_tick      (w_tick),
      .o_state     (w_state[i]),
      .o_count     (w_count[i])
    );
    a_hit_live: assert property (@(posedge pclk) disable iff (!rst_n) w_state[i] != HIT || w_count[i] != 8'd0);
  end
  // Holes never overlap, so at most one match selects a colour
  always_comb begin
    w_pix = r_rgb1;
    for (int i = 0; i < N; i++) w_pix = w_in[i] ? state_clr(w_state[i], EMPTY_CLR, OCC_CLR, HIT_CLR) : w_pix;
  end
  // Stage 1: match vectors, blank flag, upstream pixel and timing bus
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      r_t1    <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_blank <= 1'b0;
      r_rgb1  <= '0;
    end else begin
      r_t1    <= w_tin;
      r_col   <= w_col;
      r_row   <= w_row;
      r_blank <= hblnk_in | vblnk_in;
      r_rgb1  <= rgb_in;
    end
  // Stage 2: live state lookup and blank-forced colour mux
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      r_t2   <= '0;
      r_rgb2 <= '0;
    end else begin
      r_t2   <= r_t1;
      r_rgb2 <= r_blank ? 12'h000 : w_pix;
    end
  // Frame tick history and acknowledge of a hit landing on an occupied hole
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      r_vblnk   <= 1'b0;
      r_hit_ack <= 1'b0;
    end else begin
      r_vblnk   <= vblnk_in;
      r_hit_ack <= cmd_op == OP_HIT && |(w_sel & w_occ);
    end
  assign hcount_out = r_t2.hc;
  assign vcount_out = r_t2.vc;
  assign hsync_out  = r_t2.hs;
  assign hblnk_out  = r_t2.hb;
  assign vsync_out  = r_t2.vs;
  assign vblnk_out  = r_t2.vb;
  assign rgb_out    = r_rgb2;
  assign occ_mask   = w_occ;
  assign hit_ack    = r_hit_ack;
endmodule

// File: tb/tb_draw_hole_grid.sv
// tb_draw_hole_grid: model-checked randomized and directed bench for draw_hole_grid
module tb_draw_hole_grid;
  localparam int R = 3, C = 3, N = 9, OX = 185, OY = 135, PX = 200, PY = 150, HS = 50, HF = 30;
  logic        pclk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_idx;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out, hit_ack;
  logic [11:0] rgb_out;
  logic [N-1:0] occ_mask;
  logic        c2_valid;
  logic [1:0]  c2_op;
  logic [5:0]  c2_idx;
  logic [10:0] o2_hc, o2_vc;
  logic        o2_hs, o2_hb, o2_vs, o2_vb, o2_ack;
  logic [11:0] o2_rgb;
  logic [7:0]  o2_occ;
  int errs = 0, checks = 0;
  always #5 pclk = ~pclk;
  draw_hole_grid dut (
    .pclk(pclk), .rst_n(rst_n), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out), .occ_mask(occ_mask), .hit_ack(hit_ack)
  );
  draw_hole_grid #(.ROWS(2), .COLS(4), .PITCH_X(64), .HOLE_SIZE(64)) dut2 (
    .pclk(pclk), .rst_n(rst_n), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .cmd_valid(c2_valid), .cmd_op(c2_op), .cmd_idx(c2_idx),
    .hcount_out(o2_hc), .vcount_out(o2_vc), .hsync_out(o2_hs), .hblnk_out(o2_hb),
    .vsync_out(o2_vs), .vblnk_out(o2_vb), .rgb_out(o2_rgb), .occ_mask(o2_occ), .hit_ack(o2_ack)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: hole states as plain integers (0 empty, 1 occupied, 2 hit) with frames left
  int m_st [N];
  int m_cnt [N];
  logic m_vbp;
  int s_h, s_v, e_h, e_v;
  logic s_hs, s_hb, s_vs, s_vb, e_hs, e_hb, e_vs, e_vb, e_ack;
  logic [11:0] s_rgb, e_rgb;
  logic tk;
  assign tk = vblnk_in && !m_vbp;
  function automatic logic [11:0] clr_of(int s);
    return s == 1 ? 12'hA50 : s == 2 ? 12'hF00 : 12'h000;
  endfunction
  function automatic logic [11:0] exp_pix();
    int dx, dy;
    dx = s_h - OX;
    dy = s_v - OY;
    if (s_hb || s_vb) return 12'h000;
    if (dx >= 0 && dy >= 0 && dx / PX < C && dy / PY < R && dx % PX < HS && dy % PY < HS)
      return clr_of(m_st[(dy / PY) * C + dx / PX]);
    return s_rgb;
  endfunction
  function automatic bit takes(int i);
    if (!cmd_valid || int'(cmd_idx) != i) return 0;
    return (cmd_op == 2'd1 && m_st[i] == 0) || (cmd_op == 2'd3 && m_st[i] == 1) || (cmd_op == 2'd2 && m_st[i] != 0);
  endfunction
  function automatic int nxt_st(int i);
    if (takes(i)) return cmd_op == 2'd1 ? 1 : cmd_op == 2'd3 ? 2 : 0;
    if (tk && m_st[i] == 2 && m_cnt[i] == 1) return 0;
    return m_st[i];
  endfunction
  function automatic int nxt_cnt(int i);
    if (takes(i)) return cmd_op == 2'd3 ? HF : cmd_op == 2'd2 ? 0 : m_cnt[i];
    if (tk && m_st[i] == 2) return m_cnt[i] - 1;
    return m_cnt[i];
  endfunction
  function automatic logic [N-1:0] exp_occ();
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = m_st[i] == 1;
    return m;
  endfunction
  always @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] <= 0;
        m_cnt[i] <= 0;
      end
      m_vbp <= 0;
      s_h <= 0; s_v <= 0; s_hs <= 0; s_hb <= 0; s_vs <= 0; s_vb <= 0; s_rgb <= 0;
      e_h <= 0; e_v <= 0; e_hs <= 0; e_hb <= 0; e_vs <= 0; e_vb <= 0; e_rgb <= 0; e_ack <= 0;
    end else begin
      e_rgb <= exp_pix();
      e_h <= s_h; e_v <= s_v; e_hs <= s_hs; e_hb <= s_hb; e_vs <= s_vs; e_vb <= s_vb;
      e_ack <= cmd_valid && cmd_op == 2'd3 && int'(cmd_idx) < N && m_st[int'(cmd_idx) % N] == 1;
      for (int i = 0; i < N; i++) begin
        m_st[i] <= nxt_st(i);
        m_cnt[i] <= nxt_cnt(i);
      end
      m_vbp <= vblnk_in;
      s_h <= int'(hcount_in); s_v <= int'(vcount_in);
      s_hs <= hsync_in; s_hb <= hblnk_in; s_vs <= vsync_in; s_vb <= vblnk_in; s_rgb <= rgb_in;
    end
  always @(negedge pclk) begin
    chk("rgb_out", rgb_out, e_rgb);
    chk("hcount_out", hcount_out, e_h);
    chk("vcount_out", vcount_out, e_v);
    chk("sync/blank bus", {hsync_out, hblnk_out, vsync_out, vblnk_out}, {e_hs, e_hb, e_vs, e_vb});
    chk("occ_mask", occ_mask, exp_occ());
    chk("hit_ack", hit_ack, e_ack);
  end
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask
  task automatic drive(input int h, input int v, input logic [11:0] rgb, input logic hb);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in = rgb;
    hblnk_in = hb;
    cyc();
    cyc();
  endtask
  task automatic probe(input string nm, input int h, input int v, input logic [11:0] rgb, input logic [11:0] exp);
    drive(h, v, rgb, 1'b0);
    chk(nm, rgb_out, exp);
  endtask
  task automatic cmd(input logic [1:0] op, input int idx);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_idx = 6'(idx);
    cyc();
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
  endtask
  task automatic frame();
    vblnk_in = 1'b1;
    cyc();
    vblnk_in = 1'b0;
    cyc();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [11:0] px;
    int n_end;
    rst_n = 1'b1;
    {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in} = '0;
    {cmd_valid, cmd_op, cmd_idx, c2_valid, c2_op, c2_idx} = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("reset rgb_out", rgb_out, 12'h000);
    chk("reset hcount_out", hcount_out, 11'd0);
    chk("reset occ_mask", occ_mask, 9'h000);
    chk("reset hit_ack", hit_ack, 1'b0);
    rst_n = 1'b1;
    cyc();
    probe("edge 185,135", 185, 135, 12'hFFF, 12'h000);
    probe("edge 234,184", 234, 184, 12'hFFF, 12'h000);
    probe("edge 235,135", 235, 135, 12'hFFF, 12'hFFF);
    probe("edge 184,135", 184, 135, 12'hFFF, 12'hFFF);
    probe("edge 385,285", 385, 285, 12'hFFF, 12'h000);
    cmd(2'd1, 4);
    chk("occupy 4 mask", occ_mask, 9'h010);
    probe("occupied colour", 400, 300, 12'hFFF, 12'hA50);
    cmd(2'd3, 0);
    chk("hit on EMPTY no ack", hit_ack, 1'b0);
    chk("hit on EMPTY no change", occ_mask, 9'h010);
    cmd(2'd1, 9);
    chk("occupy idx 9 ignored", occ_mask, 9'h010);
    cmd(2'd3, 4);
    chk("hit ack pulse", hit_ack, 1'b1);
    cyc();
    chk("hit ack single", hit_ack, 1'b0);
    probe("hit colour", 400, 300, 12'hFFF, 12'hF00);
    n_end = 0;
    for (int n = 1; n <= 40 && n_end == 0; n++) begin
      frame();
      if (n == 10) begin
        cmd(2'd3, 4);
        chk("hit during HIT no ack", hit_ack, 1'b0);
      end
      drive(400, 300, 12'hFFF, 1'b0);
      px = rgb_out;
      if (px !== 12'hF00) n_end = n;
    end
    chk("HIT frame count", n_end, HF);
    chk("after timeout colour", px, 12'h000);
    chk("after timeout mask", occ_mask, 9'h000);
    cmd(2'd1, 2);
    cmd(2'd3, 2);
    repeat (HF - 1) frame();
    probe("hole2 last HIT frame", 600, 150, 12'hFFF, 12'hF00);
    vblnk_in = 1'b1;
    cmd(2'd2, 2);
    vblnk_in = 1'b0;
    cyc();
    chk("clear+tick mask", occ_mask, 9'h000);
    probe("clear+tick colour", 600, 150, 12'hFFF, 12'h000);
    frame();
    probe("clear+tick stays empty", 600, 150, 12'hFFF, 12'h000);
    c2_valid = 1'b1; c2_op = 2'd1; c2_idx = 6'd1;
    cyc();
    c2_valid = 1'b0; c2_op = 2'd0;
    chk("grid2 mask", o2_occ, 8'h02);
    drive(248, 135, 12'hFFF, 1'b0);
    chk("grid2 col0 last px", o2_rgb, 12'h000);
    drive(249, 135, 12'hFFF, 1'b0);
    chk("grid2 col1 first px", o2_rgb, 12'hA50);
    drive(312, 135, 12'hFFF, 1'b0);
    chk("grid2 col1 last px", o2_rgb, 12'hA50);
    drive(313, 135, 12'hFFF, 1'b0);
    chk("grid2 col2 first px", o2_rgb, 12'h000);
    drive(441, 135, 12'hFFF, 1'b0);
    chk("grid2 past grid", o2_rgb, 12'hFFF);
    drive(249, 135, 12'hFFF, 1'b1);
    chk("grid2 hblank", o2_rgb, 12'h000);
    chk("grid1 hblank", rgb_out, 12'h000);
    cmd(2'd1, 4);
    probe("pre-reset colour", 400, 300, 12'hFFF, 12'hA50);
    #2 rst_n = 1'b0;
    #1;
    chk("midline reset rgb", rgb_out, 12'h000);
    chk("midline reset hcount", hcount_out, 11'd0);
    chk("midline reset mask", occ_mask, 9'h000);
    chk("midline reset grid2 mask", o2_occ, 8'h00);
    @(posedge pclk);
    #1 rst_n = 1'b1;
    probe("post-reset outside", 100, 100, 12'h5A3, 12'h5A3);
    probe("post-reset inside", 400, 300, 12'hFFF, 12'h000);
    for (int k = 0; k < 4000; k++) begin
      hcount_in = $urandom_range(1) ? 11'($urandom_range(1023)) : 11'($urandom_range(700, 150));
      vcount_in = 11'($urandom_range(600, 100));
      rgb_in = 12'($urandom);
      hsync_in = 1'($urandom_range(1));
      vsync_in = 1'($urandom_range(1));
      hblnk_in = $urandom_range(15) == 0;
      if ($urandom_range(7) == 0) vblnk_in = ~vblnk_in;
      cmd_valid = $urandom_range(3) == 0;
      cmd_op = 2'($urandom);
      cmd_idx = 6'($urandom_range(11));
      cyc();
    end
    cmd_valid = 1'b0;
    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/draw_hole_grid.md
# draw_hole_grid

Parametrised hole-grid renderer for the game display pipeline. It overlays a ROWS×COLS grid of square holes onto the incoming VGA pixel stream and keeps a per-hole state machine (empty / occupied / hit) driven by game-logic commands. Each state draws its own colour. Hit holes time out on frame boundaries. It sits in the drawing chain between the background stage and the sprite/text stages, passing the timing bus through with fixed latency.

## Interface
- ROWS, 3, grid rows (1..8)
- COLS, 3, grid columns (1..8)
- ORIGIN_X, 185, hcount of the left edge of column 0
- ORIGIN_Y, 135, vcount of the top edge of row 0
- PITCH_X, 200, horizontal distance between column left edges; must be ≥ HOLE_SIZE
- PITCH_Y, 150, vertical distance between row top edges; must be ≥ HOLE_SIZE
- HOLE_SIZE, 50, hole edge length in pixels; 0 disables drawing
- EMPTY_CLR, 12'h000, colour of an EMPTY hole
- OCC_CLR, 12'hA50, colour of an OCCUPIED hole
- HIT_CLR, 12'hF00, colour of a HIT hole
- HIT_FRAMES, 30, frames a hole stays HIT (1..255)
- Clock and reset: one clock; reset is asynchronous and active-low.
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcount_in, vcount_in  in  11  pixel counters
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1  timing bus
- rgb_in  in  12  upstream pixel
- cmd_valid  in  1  one-cycle command strobe
- cmd_op  in  2  command: 0 = nop, 1 = occupy, 2 = clear, 3 = hit
- cmd_idx  in  6  hole index, row*COLS+col
- hcount_out, vcount_out  out  11  counters delayed 2 cycles
- hsync_out, hblnk_out, vsync_out, vblnk_out  out  1  timing bus delayed 2 cycles
- rgb_out  out  12  composited pixel
- occ_mask  out  ROWS*COLS  bit i is set while hole i is OCCUPIED
- hit_ack  out  1  one-cycle pulse: a hit command landed on an OCCUPIED hole

## Operation
- Per-hole FSM states: EMPTY, OCCUPIED, HIT, each with an 8-bit countdown.
  - EMPTY → OCCUPIED on occupy.
  - OCCUPIED → HIT on hit; the countdown loads HIT_FRAMES and hit_ack pulses on the next cycle.
  - OCCUPIED or HIT → EMPTY on clear.
  - HIT → EMPTY when the countdown reaches 0.
  - All other command/state pairs are ignored. A hit on an EMPTY or HIT hole does not pulse hit_ack.
- Frame tick: rising edge of vblnk_in, detected with a registered copy. Each HIT countdown decrements by 1 per tick. When it reaches 0, the hole returns to EMPTY on that same cycle.
- A command and a frame tick in the same cycle for the same hole: the command wins, and the countdown is not decremented.
- cmd_idx ≥ ROWS*COLS: the command is ignored, no state changes, no hit_ack.
- Hit test is inclusive-exclusive on every hole:
  - ORIGIN_X + c·PITCH_X ≤ hcount < ORIGIN_X + c·PITCH_X + HOLE_SIZE
  - the same rule applies vertically with ORIGIN_Y, PITCH_Y and the row index
- Comparisons are done at 12-bit width so the edge sums cannot overflow. Because PITCH ≥ HOLE_SIZE, holes never overlap.
- Pixel priority:
  - during hblnk or vblnk → 12'h000
  - inside hole i → the colour for hole i's state
  - otherwise → rgb_in
- Reset (asynchronous, at any point including mid-frame): all outputs 0, every hole EMPTY, countdowns 0, occ_mask 0, hit_ack 0.

## Timing
- Pixel path latency: 2 cycles, applied equally to the whole timing bus and rgb.
  - Stage 1 registers the column-match vector, the row-match vector, the blank flag and rgb_in.
  - Stage 2 registers the state lookup and the colour mux.
- A command sampled at edge N changes hole state at N. Pixels entering stage 2 after edge N use the new state.
- Colour changes take effect immediately (mid-frame tearing is accepted).
- occ_mask is registered and reflects state after edge N.
- hit_ack is registered and asserts during the cycle after the accepting edge.

## Structure
- Package draw_hole_pkg: hole-state enum (EMPTY=2'd0, OCCUPIED=2'd1, HIT=2'd2), cmd_op encodings, and the default colour constants.
- Sub-module hole_cell, instantiated ROWS*COLS times via generate.
  - Inputs: idx-matched command, frame tick.
  - Outputs: state and countdown.
- The top level holds the timing pipeline, the match comparators, the tick detector and the colour mux.

## Test plan
- Reset mid-line: drop rst_n at hcount=400 → all outputs 0 immediately. After release, rgb_out equals rgb_in delayed 2 cycles outside holes, and EMPTY_CLR inside holes.
- Edge pixels, default parameters, all holes EMPTY, rgb_in=12'hFFF:
  - (185,135) → 12'h000
  - (234,184) → 12'h000
  - (235,135) → 12'hFFF
  - (184,135) → 12'hFFF
  - (385,285) → 12'h000
- Occupy idx 4 → occ_mask=9'h010, and pixel (400,300) is 12'hA50. Hit idx 4 → hit_ack pulses once, and the pixel is 12'hF00 for exactly 30 vblnk rising edges, then 12'h000 with occ_mask=0.
- Invalid index and nop commands:
  - hit on EMPTY idx 0 → no hit_ack, no change
  - occupy idx 9 with 3×3 → ignored
  - second hit during HIT → countdown not reloaded
- Command and frame tick in the same cycle: hole 2 HIT with countdown 1, clear issued in the tick cycle → EMPTY with countdown 0, no spurious transition.
- Parameter sweep: ROWS=2, COLS=4, PITCH_X=HOLE_SIZE=64 (adjacent holes) → pixel 64+ORIGIN_X belongs to column 1 only. Blanking forces 12'h000 even inside hole coordinates.
